// File: rtl/wb_rr_arbiter_if.sv
// Request/grant bundle between the Wishbone masters and the round-robin arbiter.
// The slave modport is the arbiter's view. The master modport is the requesters' view.
interface wb_rr_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2
);
    logic [NUM_MASTERS-1:0] req_i;
    logic [NUM_MASTERS-1:0] lock_i;
    logic [NUM_MASTERS-1:0] gnt_o;
    logic [IDX_W-1:0]       gnt_idx_o;
    logic                   cyc_o;
    logic                   timeout_o;

    modport slave (
        input  req_i,
        input  lock_i,
        output gnt_o,
        output gnt_idx_o,
        output cyc_o,
        output timeout_o
    );

    modport master (
        output req_i,
        output lock_i,
        input  gnt_o,
        input  gnt_idx_o,
        input  cyc_o,
        input  timeout_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Registered Wishbone master arbiter.
// It supports round-robin or fixed-priority selection. A bounded-hold
// preemption counter limits how long one master keeps the bus, and the
// owner's LOCK signal blocks that preemption.
// Every output comes from a flop, so there is no combinational path from req/lock.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2,
    parameter int PRIO_MODE   = 0,
    parameter int MAX_HOLD    = 16,
    parameter int HOLD_W      = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    wb_rr_arbiter_if.slave         bus
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    localparam int HOLD_LIM_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_LIM_I);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_MASTERS - 1);

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
    logic                   timeout_q, timeout_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [IDX_W-1:0]       last_q, last_d;

    logic [NUM_MASTERS-1:0] others;
    logic [IDX_W-1:0]       win_all;
    logic [IDX_W-1:0]       win_others;

    // Pick a winner from a request vector.
    // Fixed priority takes the lowest set index.
    // Round-robin scans from last+1 and wraps around.
    function automatic logic [IDX_W-1:0] pick_winner(
        input logic [NUM_MASTERS-1:0] r,
        input logic [IDX_W-1:0]       last
    );
        logic [IDX_W-1:0] w;
        logic             found;
        int               k;
        w     = '0;
        found = 1'b0;
        k     = 0;
        if (PRIO_MODE != 0) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (r[i]) w = IDX_W'(i);
            end
        end else begin
            for (int i = 1; i <= NUM_MASTERS; i++) begin
                k = (int'(last) + i) % NUM_MASTERS;
                if (!found && r[k]) begin
                    w     = IDX_W'(k);
                    found = 1'b1;
                end
            end
        end
        return w;
    endfunction

    // Candidate winners: one from all requests, one with the current owner masked out.
    always_comb begin
        others     = bus.req_i & ~gnt_q;
        win_all    = pick_winner(bus.req_i, last_q);
        win_others = pick_winner(others, last_q);
    end

    // Next-state logic covers grant, release, handover, hold counting and preemption.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        last_d    = last_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_i) begin
                    state_d   = BUSY;
                    gnt_d     = NUM_MASTERS'(1) << win_all;
                    gnt_idx_d = win_all;
                    last_d    = win_all;
                    hold_d    = '0;
                end
            end
            BUSY: begin
                if (!bus.req_i[gnt_idx_q]) begin
                    // A release takes precedence over a coincident hold limit.
                    // In that case no timeout is signalled.
                    hold_d = '0;
                    if (|others) begin
                        gnt_d     = NUM_MASTERS'(1) << win_others;
                        gnt_idx_d = win_others;
                        last_d    = win_others;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_q >= HOLD_LIM) && (|others)
                             && !bus.lock_i[gnt_idx_q]) begin
                    gnt_d     = NUM_MASTERS'(1) << win_others;
                    gnt_idx_d = win_others;
                    last_d    = win_others;
                    hold_d    = '0;
                    timeout_d = 1'b1;
                end else if (hold_q < HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and output registers.
    // Reset clears the grant immediately and parks the pointer so that master 0 wins first.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            last_q    <= LAST_RST;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
        end
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.gnt_idx_o = gnt_idx_q;
    assign bus.cyc_o     = |gnt_q;
    assign bus.timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter using three instances.
// Instance rr runs round-robin with a long hold limit.
// Instance ph runs round-robin with MAX_HOLD=4 to exercise preemption.
// Instance fp runs fixed priority.
module tb_wb_rr_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    wb_rr_arbiter_if #(.NUM_MASTERS(4), .IDX_W(2)) if_rr ();
    wb_rr_arbiter_if #(.NUM_MASTERS(4), .IDX_W(2)) if_ph ();
    wb_rr_arbiter_if #(.NUM_MASTERS(4), .IDX_W(2)) if_fp ();

    wb_rr_arbiter #(.NUM_MASTERS(4), .IDX_W(2), .PRIO_MODE(0), .MAX_HOLD(16), .HOLD_W(5))
        dut_rr (.clk_i(clk), .rst_n_i(rst_n), .bus(if_rr));
    wb_rr_arbiter #(.NUM_MASTERS(4), .IDX_W(2), .PRIO_MODE(0), .MAX_HOLD(4), .HOLD_W(5))
        dut_ph (.clk_i(clk), .rst_n_i(rst_n), .bus(if_ph));
    wb_rr_arbiter #(.NUM_MASTERS(4), .IDX_W(2), .PRIO_MODE(1), .MAX_HOLD(16), .HOLD_W(5))
        dut_fp (.clk_i(clk), .rst_n_i(rst_n), .bus(if_fp));

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and count the result.
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns past it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Check the grant, index, cyc and timeout of one instance together.
    task automatic checkRr(input string tag, input logic [3:0] g, input logic [1:0] idx,
                           input logic c, input logic t);
        checkOutput({tag, ".gnt"}, 8'(if_rr.gnt_o), 8'(g));
        checkOutput({tag, ".idx"}, 8'(if_rr.gnt_idx_o), 8'(idx));
        checkOutput({tag, ".cyc"}, 8'(if_rr.cyc_o), 8'(c));
        checkOutput({tag, ".tmo"}, 8'(if_rr.timeout_o), 8'(t));
    endtask

    task automatic checkPh(input string tag, input logic [3:0] g, input logic t);
        checkOutput({tag, ".gnt"}, 8'(if_ph.gnt_o), 8'(g));
        checkOutput({tag, ".tmo"}, 8'(if_ph.timeout_o), 8'(t));
    endtask

    task automatic checkFp(input string tag, input logic [3:0] g);
        checkOutput({tag, ".gnt"}, 8'(if_fp.gnt_o), 8'(g));
    endtask

    // Directed sequence. Each step sets the inputs, clocks, and checks the outputs.
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        if_rr.req_i = 4'b0000; if_rr.lock_i = 4'b0000;
        if_ph.req_i = 4'b0000; if_ph.lock_i = 4'b0000;
        if_fp.req_i = 4'b0000; if_fp.lock_i = 4'b0000;

        #3;
        checkRr("reset_rr", 4'b0000, 2'd0, 1'b0, 1'b0);
        checkPh("reset_ph", 4'b0000, 1'b0);
        checkFp("reset_fp", 4'b0000);

        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
        checkRr("post_reset_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Rotation with all four masters requesting.
        // Each owner drops its request for one cycle after holding the grant for 3 cycles.
        $display("[TB] round-robin rotation");
        if_rr.req_i = 4'b1111;
        applyStimulus();
        checkRr("rot_first", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int m = 0; m < 4; m++) begin
            applyStimulus();
            applyStimulus();
            checkRr("rot_hold", 4'(1 << m), 2'(m), 1'b1, 1'b0);
            if_rr.req_i = 4'b1111 & ~4'(1 << m);
            applyStimulus();
            checkRr("rot_next", 4'(1 << ((m + 1) % 4)), 2'((m + 1) % 4), 1'b1, 1'b0);
            if_rr.req_i = 4'b1111;
        end
        if_rr.req_i = 4'b0000;
        applyStimulus();
        checkRr("rot_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // A single late request gets a 1-cycle grant latency.
        // Dropping the request returns the arbiter to idle, and the index keeps its last value.
        $display("[TB] single request latency");
        applyStimulus();
        applyStimulus();
        if_rr.req_i = 4'b0100;
        applyStimulus();
        checkRr("single_gnt", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkRr("single_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        if_rr.req_i = 4'b0000;
        applyStimulus();
        checkRr("single_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

        // Hold-limit preemption with MAX_HOLD=4 and master 3 waiting.
        $display("[TB] hold-limit preemption");
        if_ph.req_i = 4'b0010;
        applyStimulus();
        checkPh("pre_gnt", 4'b0010, 1'b0);
        if_ph.req_i = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkPh("pre_wait", 4'b0010, 1'b0);
        end
        applyStimulus();
        checkPh("pre_fire", 4'b1000, 1'b1);
        checkOutput("pre_fire.idx", 8'(if_ph.gnt_idx_o), 8'd3);
        applyStimulus();
        checkPh("pre_after1", 4'b1000, 1'b0);
        applyStimulus();
        checkPh("pre_after2", 4'b1000, 1'b0);
        if_ph.req_i = 4'b0010;
        applyStimulus();
        checkPh("pre_regrant", 4'b0010, 1'b0);
        if_ph.req_i = 4'b0000;
        applyStimulus();
        checkPh("pre_idle", 4'b0000, 1'b0);

        // LOCK blocks preemption.
        // Preemption fires at the first edge after the owner's lock drops.
        $display("[TB] locked hold");
        if_ph.req_i  = 4'b0010;
        if_ph.lock_i = 4'b0010;
        applyStimulus();
        checkPh("lock_gnt", 4'b0010, 1'b0);
        if_ph.req_i = 4'b1010;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkPh("lock_hold", 4'b0010, 1'b0);
        end
        if_ph.lock_i = 4'b0000;
        applyStimulus();
        checkPh("lock_fire", 4'b1000, 1'b1);
        if_ph.req_i = 4'b0000;
        applyStimulus();
        checkPh("lock_idle", 4'b0000, 1'b0);

        // Fixed priority: the lower index wins.
        // A returning master 1 does not take the bus from master 3.
        $display("[TB] fixed priority");
        if_fp.req_i = 4'b1010;
        applyStimulus();
        checkFp("fp_low_wins", 4'b0010);
        if_fp.req_i = 4'b1000;
        applyStimulus();
        checkFp("fp_handover", 4'b1000);
        if_fp.req_i = 4'b1010;
        applyStimulus();
        checkFp("fp_no_steal1", 4'b1000);
        applyStimulus();
        checkFp("fp_no_steal2", 4'b1000);
        if_fp.req_i = 4'b0010;
        applyStimulus();
        checkFp("fp_back", 4'b0010);
        if_fp.req_i = 4'b0000;
        applyStimulus();
        checkFp("fp_idle", 4'b0000);

        // Round-robin pointer: last grant was master 2, so master 3 is next.
        // Then assert reset asynchronously in the middle of the cycle.
        $display("[TB] async reset mid-grant");
        if_rr.req_i = 4'b1111;
        applyStimulus();
        checkRr("ptr_next", 4'b1000, 2'd3, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checkRr("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
        checkRr("rst_first", 4'b0001, 2'd0, 1'b1, 1'b0);
        if_rr.req_i = 4'b0000;
        applyStimulus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Registered, parametrised round-robin arbiter for the i2d SoC Wishbone intercon, successor to the combinational master arbiter. Grants one of NUM_MASTERS bus masters, holds the grant for the whole cycle, and rotates priority fairly. Adds fixed-priority mode, a bounded-hold preemption counter honouring Wishbone LOCK, and an encoded grant index for the intercon muxes.

Parameters:
NUM_MASTERS, 4, number of requesting masters (>=2)
IDX_W, 2, width of grant index; must equal ceil(log2(NUM_MASTERS))
PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, master 0 highest
MAX_HOLD, 16, max cycles one master keeps the grant while others wait; 0 disables preemption
HOLD_W, 5, hold-counter width; must hold MAX_HOLD

Ports:
clk_i  input  1  system clock, all state on rising edge
rst_n_i  input  1  asynchronous active-low reset
req_i  input  NUM_MASTERS  per-master request (master CYC)
lock_i  input  NUM_MASTERS  per-master Wishbone LOCK; blocks preemption of that master
gnt_o  output  NUM_MASTERS  one-hot registered grant, all-zero when idle
gnt_idx_o  output  IDX_W  binary index of granted master, valid while cyc_o=1
cyc_o  output  1  bus cycle active to slaves, equals |gnt_o
timeout_o  output  1  one-cycle pulse when a hold-limit preemption occurs

Behaviour:
- Reset (rst_n_i low, asynchronous): gnt_o=0, gnt_idx_o=0, cyc_o=0, timeout_o=0, hold counter=0, last-grant pointer=NUM_MASTERS-1 so master 0 wins first after reset. Asserting reset mid-cycle drops the grant immediately. Release is synchronous to clk_i.
- States: IDLE (gnt_o=0) and BUSY (exactly one gnt bit set).
- Winner selection in round-robin mode:
  - Scan req_i starting at (last+1) mod NUM_MASTERS, wrapping. The first set bit wins.
  - last is updated to the winner on every new grant.
- Winner selection in fixed-priority mode: lowest-index set request wins; last is ignored.
- IDLE -> BUSY:
  - Any req_i bit set at an edge produces the grant at that edge, so gnt_o is visible the cycle after req is first seen (1-cycle latency).
  - Hold counter loads 0.
- BUSY, owner req high and no preemption: grant unchanged; counter increments, saturating at MAX_HOLD.
- BUSY, owner req low at an edge:
  - If other requests are pending, grant the new winner at the same edge. There is no idle cycle between owners.
  - Otherwise go to IDLE.
- Preemption:
  - Triggers when MAX_HOLD != 0, counter == MAX_HOLD-1, at least one other req is set, and lock_i[owner]=0 at an edge.
  - The grant moves to the winner chosen with the owner masked out, and timeout_o pulses for one cycle.
  - Counter reloads 0. last = new owner.
  - If lock_i[owner]=1, the counter saturates and no preemption occurs until lock drops. Preemption then fires at the first edge with lock low and others requesting.
- A preempted master still requesting re-enters normal rotation. The arbiter never regrants it without re-arbitration.
- Simultaneous owner-release and hold-limit at the same edge: treat as a normal release; timeout_o stays 0.
- gnt_idx_o and gnt_o change on the same edge and are always consistent. gnt_idx_o holds its last value in IDLE.
- No combinational path from req_i or lock_i to any output.

Test Plan:
- Reset, then req_i=4'b1111 held → gnt_o sequence 0001, 0010, 0100, 1000, 0001 as each owner drops req for one cycle after 3 granted cycles; cyc_o never low between owners.
- req_i=4'b0000, then req_i=4'b0100 at cycle 5 → gnt_o=0100, gnt_idx_o=2 from cycle 6. Drop req at cycle 9 → gnt_o=0, cyc_o=0 from cycle 10.
- MAX_HOLD=4, master 1 holds req with lock_i=0 while master 3 requests → after 4 granted cycles gnt_o=1000, one-cycle timeout_o=1. Master 1 is regranted only after master 3 releases.
- Same as previous, but lock_i[1]=1 for 10 cycles → no preemption during lock. Preemption to master 3 at the first edge after lock_i[1] falls.
- PRIO_MODE=1, req_i=4'b1010 → gnt_o=0010. Release master 1 while master 3 requests → 1000. Re-request master 1 → stays 1000 until master 3 releases.
- Assert rst_n_i low mid-grant between clock edges → gnt_o, cyc_o and timeout_o go 0 immediately. After release with req_i=4'b1111 → gnt_o=0001 first.
